// File: rtl/receptor_pkg.sv
// Shared types and constants for the serial key receiver: FSM state encoding,
// opcode/command values and the byte-to-action decoder.
package receptor_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } estado_t;

  localparam logic [1:0] OP_PRESS   = 2'b00;
  localparam logic [1:0] OP_RELEASE = 2'b01;

  localparam logic [7:0] CMD_RIGHT = 8'h80;
  localparam logic [7:0] CMD_LEFT  = 8'h81;
  localparam logic [7:0] CMD_ENTER = 8'h82;

  typedef struct packed {
    logic       press;
    logic       rel;
    logic       right;
    logic       left;
    logic       enter;
    logic       invalid;
    logic [3:0] idx;
  } cmd_t;

  // b[5:4] is deliberately ignored for press/release.
  function automatic cmd_t decode_cmd(input logic [7:0] b, input int num_botoes);
    cmd_t c;
    logic in_range;
    c        = '0;
    c.idx    = b[3:0];
    in_range = int'({28'd0, b[3:0]}) < num_botoes;
    case (b[7:6])
      OP_PRESS: begin
        c.press   = in_range;
        c.invalid = !in_range;
      end
      OP_RELEASE: begin
        c.rel     = in_range;
        c.invalid = !in_range;
      end
      2'b10: begin
        case (b)
          CMD_RIGHT: c.right   = 1'b1;
          CMD_LEFT:  c.left    = 1'b1;
          CMD_ENTER: c.enter   = 1'b1;
          default:   c.invalid = 1'b1;
        endcase
      end
      default: c.invalid = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/gerador_tick_uart.sv
// Free-running oversample tick divider: one-cycle tick every
// CLOCK_FREQ/(BAUD*OVERSAMPLE) clocks (integer-truncated).
module gerador_tick_uart #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int DIVISOR = CLOCK_FREQ / (BAUD * OVERSAMPLE);
  localparam int CW      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (count == CW'(DIVISOR - 1)) begin
      count <= '0;
      tick  <= 1'b1;
    end else begin
      count <= count + 1'b1;
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/receptor_teclado_serial.sv
// UART 8N1 receiver decoding key bytes into held note buttons and menu pulses.
// Optional auto-release of all notes after silence: define RECEPTOR_AUTO_RELEASE_EN.
module receptor_teclado_serial
  import receptor_pkg::*;
#(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int NUM_BOTOES = 13,
  parameter int TIMEOUT_MS = 500
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx,
  output logic [NUM_BOTOES-1:0] botoes,
  output logic                  right_arrow_pressed,
  output logic                  left_arrow_pressed,
  output logic                  enter_pressed,
  output logic                  byte_valid,
  output logic                  frame_error,
  output logic                  cmd_invalid,
  output logic [2:0]            db_estado,
  output logic [7:0]            db_byte
);

  localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

  logic tick;
  logic rx_meta, rx_sync;

  estado_t       state, state_next;
  logic [TW-1:0] tick_cnt, tick_cnt_next;
  logic [2:0]    bit_cnt, bit_cnt_next;
  logic [7:0]    shift, shift_next;
  logic          accept, framing_err;
  logic          expire;
  cmd_t          cmd;

  gerador_tick_uart #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );

  // Synchronizer presets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      state    <= state_next;
      tick_cnt <= tick_cnt_next;
      bit_cnt  <= bit_cnt_next;
      shift    <= shift_next;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    tick_cnt_next = tick_cnt;
    bit_cnt_next  = bit_cnt;
    shift_next    = shift;
    accept        = 1'b0;
    framing_err   = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_sync) begin
          state_next    = START;
          tick_cnt_next = '0;
        end
      end
      START: begin
        if (tick) begin
          if (tick_cnt == HALF_LAST) begin
            tick_cnt_next = '0;
            bit_cnt_next  = '0;
            state_next    = rx_sync ? IDLE : DATA;
          end else begin
            tick_cnt_next = tick_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tick_cnt == FULL_LAST) begin
            tick_cnt_next = '0;
            shift_next    = {rx_sync, shift[7:1]};
            if (bit_cnt == 3'd7) state_next = STOP;
            else                 bit_cnt_next = bit_cnt + 1'b1;
          end else begin
            tick_cnt_next = tick_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tick_cnt == FULL_LAST) begin
            tick_cnt_next = '0;
            if (rx_sync) begin
              accept     = 1'b1;
              state_next = IDLE;
            end else begin
              framing_err = 1'b1;
              state_next  = WAIT_IDLE;
            end
          end else begin
            tick_cnt_next = tick_cnt + 1'b1;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_sync) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign cmd       = decode_cmd(shift, NUM_BOTOES);
  assign db_estado = state;

`ifdef RECEPTOR_AUTO_RELEASE_EN
  localparam int TIMEOUT_CYCLES = CLOCK_FREQ / 1000 * TIMEOUT_MS;
  localparam int OW = $clog2(TIMEOUT_CYCLES + 1);

  logic [OW-1:0] silence_cnt;

  // Saturates at TIMEOUT_CYCLES so expiry fires once per silent period.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                 silence_cnt <= '0;
    else if (accept)                            silence_cnt <= '0;
    else if (silence_cnt != OW'(TIMEOUT_CYCLES)) silence_cnt <= silence_cnt + 1'b1;
  end

  assign expire = !accept && (silence_cnt == OW'(TIMEOUT_CYCLES - 1));
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      botoes              <= '0;
      right_arrow_pressed <= 1'b0;
      left_arrow_pressed  <= 1'b0;
      enter_pressed       <= 1'b0;
      byte_valid          <= 1'b0;
      frame_error         <= 1'b0;
      cmd_invalid         <= 1'b0;
      db_byte             <= '0;
    end else begin
      right_arrow_pressed <= 1'b0;
      left_arrow_pressed  <= 1'b0;
      enter_pressed       <= 1'b0;
      byte_valid          <= 1'b0;
      frame_error         <= framing_err;
      cmd_invalid         <= 1'b0;
      if (accept) begin
        byte_valid          <= 1'b1;
        db_byte             <= shift;
        right_arrow_pressed <= cmd.right;
        left_arrow_pressed  <= cmd.left;
        enter_pressed       <= cmd.enter;
        cmd_invalid         <= cmd.invalid;
        if (cmd.press) botoes[cmd.idx] <= 1'b1;
        if (cmd.rel)   botoes[cmd.idx] <= 1'b0;
      end else if (expire) begin
        botoes <= '0;
      end
    end
  end

endmodule
